// File: rtl/resp_serializer.sv
// Merges the FSM echo byte stream and ALU result words into one UART byte stream.
// Result words go out LSB byte first; a packet lock keeps the two sources from interleaving.
module resp_serializer #(
    parameter int WORD_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              echo_data_i,
    input  logic                    echo_valid_i,
    input  logic                    echo_last_i,
    output logic                    echo_ready_o,
    input  logic [8*WORD_BYTES-1:0] res_data_i,
    input  logic                    res_valid_i,
    output logic                    res_ready_o,
    output logic [7:0]              data_o,
    output logic                    valid_o,
    input  logic                    ready_i
);

    localparam int SH_W  = 8 * WORD_BYTES;
    localparam int CNT_W = $clog2(WORD_BYTES + 1);

    typedef enum logic [1:0] {
        IDLE,
        ECHO,
        RESULT
    } state_t;

    state_t            state_q, state_d;
    logic [SH_W-1:0]   sh_q, sh_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sh_d         = sh_q;
        cnt_d        = cnt_q;
        echo_ready_o = 1'b0;
        res_ready_o  = 1'b0;
        valid_o      = 1'b0;
        data_o       = 8'h00;

        // Outputs stay quiet for the whole reset cycle, whatever state we were in.
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    res_ready_o = 1'b1;
                    if (res_valid_i) begin
                        sh_d    = res_data_i;
                        cnt_d   = CNT_W'(WORD_BYTES);
                        state_d = RESULT;
                    end else if (echo_valid_i) begin
                        state_d = ECHO;
                    end
                end

                ECHO: begin
                    valid_o      = echo_valid_i;
                    data_o       = echo_valid_i ? echo_data_i : 8'h00;
                    echo_ready_o = ready_i;
                    if (echo_valid_i && ready_i && echo_last_i) begin
                        state_d = IDLE;
                    end
                end

                RESULT: begin
                    valid_o = 1'b1;
                    data_o  = sh_q[7:0];
                    if (ready_i) begin
                        if (cnt_q == CNT_W'(1)) begin
                            sh_d    = '0;
                            cnt_d   = '0;
                            state_d = IDLE;
                        end else begin
                            sh_d  = sh_q >> 8;
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_resp_serializer.sv
// Bench for resp_serializer: directed scenarios on 4-byte and 1-byte instances, then
// randomized traffic scored against an in-order byte queue built from accepted inputs.
module tb_resp_serializer;

    localparam int WB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [7:0]    echo_data;
    logic          echo_valid, echo_last, echo_ready;
    logic [31:0]   res_data;
    logic          res_valid, res_ready;
    logic [7:0]    data_o;
    logic          valid_o, ready;

    logic [7:0]    e1_data;
    logic          e1_valid, e1_last, e1_ready;
    logic [7:0]    r1_data;
    logic          r1_valid, r1_ready;
    logic [7:0]    d1;
    logic          v1, rdy1;

    resp_serializer #(.WORD_BYTES(WB)) dut4 (
        .clk(clk), .rst(rst),
        .echo_data_i(echo_data), .echo_valid_i(echo_valid), .echo_last_i(echo_last),
        .echo_ready_o(echo_ready),
        .res_data_i(res_data), .res_valid_i(res_valid), .res_ready_o(res_ready),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready)
    );

    resp_serializer #(.WORD_BYTES(1)) dut1 (
        .clk(clk), .rst(rst),
        .echo_data_i(e1_data), .echo_valid_i(e1_valid), .echo_last_i(e1_last),
        .echo_ready_o(e1_ready),
        .res_data_i(r1_data), .res_valid_i(r1_valid), .res_ready_o(r1_ready),
        .data_o(d1), .valid_o(v1), .ready_i(rdy1)
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];
    bit          hold_pend;
    logic [7:0]  hold_data;
    bit          res_acc, echo_acc;
    int          ep_left;
    bit          drained;

    logic [7:0]  t1[4];
    logic [7:0]  bp_exp[7];
    logic        bp_rdy[7];
    logic [7:0]  t4a[4];
    logic [7:0]  t4b[4];
    logic [7:0]  t5[4];
    logic [7:0]  b2b[4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: output stream equals the accepted inputs in acceptance order,
    // result words expanded LSB byte first; a stalled byte must not change.
    task automatic sb();
        if (rst) begin
            chk("rst_out4", {valid_o, data_o, echo_ready, res_ready}, 64'd0);
            chk("rst_out1", {v1, d1, e1_ready, r1_ready}, 64'd0);
            exp_q.delete();
            hold_pend = 1'b0;
            res_acc   = 1'b0;
            echo_acc  = 1'b0;
            return;
        end
        res_acc  = res_valid && res_ready;
        echo_acc = echo_valid && echo_ready;
        if (res_acc)
            for (int i = 0; i < WB; i++) exp_q.push_back(res_data[8*i +: 8]);
        if (echo_acc) exp_q.push_back(echo_data);
        if (hold_pend) chk("hold", {valid_o, data_o}, {1'b1, hold_data});
        if (valid_o && ready) begin
            if (exp_q.size() == 0) chk("extra_byte", {1'b1, data_o}, 64'd0);
            else chk("stream", data_o, exp_q.pop_front());
        end
        hold_pend = valid_o && !ready;
        hold_data = data_o;
    endtask

    task automatic neg();
        @(negedge clk);
        sb();
    endtask

    task automatic pos();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_drive(input bit new_ok);
        if (res_acc) res_valid = 1'b0;
        if (echo_acc) begin
            echo_valid = 1'b0;
            echo_last  = 1'b0;
            ep_left--;
        end
        if (!res_valid && new_ok && $urandom_range(0, 7) == 0) begin
            res_valid = 1'b1;
            res_data  = $urandom;
        end
        if (!echo_valid && (ep_left > 0 || new_ok) && $urandom_range(0, 2) == 0) begin
            if (ep_left == 0) ep_left = $urandom_range(1, 4);
            echo_valid = 1'b1;
            echo_data  = 8'($urandom);
            echo_last  = (ep_left == 1);
        end
        ready = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        t1     = '{8'h44, 8'h33, 8'h22, 8'h11};
        bp_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        bp_exp = '{8'h44, 8'h33, 8'h33, 8'h33, 8'h22, 8'h22, 8'h11};
        t4a    = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        t4b    = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
        t5     = '{8'h04, 8'h03, 8'h02, 8'h01};
        b2b    = '{8'h5A, 8'h3C, 8'h81, 8'hF0};

        rst = 1'b1;
        echo_data = 8'h00; echo_valid = 1'b0; echo_last = 1'b0;
        res_data = 32'hCAFEF00D; res_valid = 1'b1; ready = 1'b1;
        e1_data = 8'h00; e1_valid = 1'b0; e1_last = 1'b0;
        r1_data = 8'h00; r1_valid = 1'b0; rdy1 = 1'b0;
        ep_left = 0; hold_pend = 1'b0; res_acc = 1'b0; echo_acc = 1'b0;
        #1;
        repeat (2) begin neg(); pos(); end
        rst = 1'b0; res_valid = 1'b0;

        // Basic result word
        neg();
        chk("idle_res_ready", res_ready, 1);
        chk("idle_valid", valid_o, 0);
        chk("idle_echo_ready", echo_ready, 0);
        pos();
        res_data = 32'h11223344; res_valid = 1'b1;
        neg(); chk("t1_accept", res_ready, 1); pos();
        res_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            neg();
            chk("t1_valid", valid_o, 1);
            chk("t1_data", data_o, t1[i]);
            chk("t1_res_ready", res_ready, 0);
            pos();
        end
        neg(); chk("t1_done_valid", valid_o, 0); chk("t1_done_idle", res_ready, 1); pos();

        // Backpressure
        res_valid = 1'b1;
        neg(); chk("t2_accept", res_ready, 1); pos();
        res_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            ready = bp_rdy[i];
            neg();
            chk("t2_valid", valid_o, 1);
            chk("t2_data", data_o, bp_exp[i]);
            pos();
        end
        ready = 1'b1;
        neg(); chk("t2_done_valid", valid_o, 0); pos();

        // Echo packet AA BB CC
        echo_valid = 1'b1; echo_data = 8'hAA; echo_last = 1'b0;
        neg(); chk("t3_bubble_valid", valid_o, 0); chk("t3_bubble_ready", echo_ready, 0); pos();
        neg(); chk("t3_aa", {valid_o, data_o, echo_ready}, {1'b1, 8'hAA, 1'b1}); pos();
        echo_data = 8'hBB; ready = 1'b0;
        neg(); chk("t3_bb_stall", {valid_o, data_o, echo_ready}, {1'b1, 8'hBB, 1'b0}); pos();
        ready = 1'b1;
        neg(); chk("t3_bb", {valid_o, data_o, echo_ready}, {1'b1, 8'hBB, 1'b1}); pos();
        echo_data = 8'hCC; echo_last = 1'b1;
        neg(); chk("t3_cc", {valid_o, data_o, res_ready}, {1'b1, 8'hCC, 1'b0}); pos();
        echo_valid = 1'b0; echo_last = 1'b0;
        neg(); chk("t3_idle", {valid_o, res_ready}, {1'b0, 1'b1}); pos();

        // Simultaneous sources, then a result raised mid-packet
        res_data = 32'hA1B2C3D4; res_valid = 1'b1;
        echo_valid = 1'b1; echo_data = 8'h5E; echo_last = 1'b0;
        neg(); chk("t4_res_wins", {res_ready, echo_ready}, {1'b1, 1'b0}); pos();
        res_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            neg();
            chk("t4_word", {valid_o, data_o}, {1'b1, t4a[i]});
            chk("t4_echo_wait", echo_ready, 0);
            pos();
        end
        neg(); chk("t4_bubble", {valid_o, res_ready}, {1'b0, 1'b1}); pos();
        res_valid = 1'b1; res_data = 32'h0D0C0B0A;
        neg(); chk("t4_5e", {valid_o, data_o}, {1'b1, 8'h5E}); chk("t4_res_blocked", res_ready, 0); pos();
        echo_data = 8'h6F; echo_last = 1'b1;
        neg(); chk("t4_6f", {valid_o, data_o}, {1'b1, 8'h6F}); chk("t4_res_blocked2", res_ready, 0); pos();
        echo_valid = 1'b0; echo_last = 1'b0;
        neg(); chk("t4_res_accept", {res_ready, valid_o}, {1'b1, 1'b0}); pos();
        res_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            neg(); chk("t4_word2", {valid_o, data_o}, {1'b1, t4b[i]}); pos();
        end
        neg(); chk("t4_done", valid_o, 0); pos();

        // Reset mid-word
        res_data = 32'hDEADBEEF; res_valid = 1'b1;
        neg(); pos();
        res_valid = 1'b0;
        neg(); chk("t5_ef", data_o, 8'hEF); pos();
        neg(); chk("t5_be", data_o, 8'hBE); pos();
        rst = 1'b1;
        repeat (2) begin neg(); pos(); end
        rst = 1'b0;
        neg(); chk("t5_idle", {res_ready, valid_o}, {1'b1, 1'b0}); pos();
        res_data = 32'h01020304; res_valid = 1'b1;
        neg(); pos();
        res_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            neg(); chk("t5_word", {valid_o, data_o}, {1'b1, t5[i]}); pos();
        end
        neg(); chk("t5_done", valid_o, 0); pos();

        // One-byte words
        r1_data = 8'h5A; r1_valid = 1'b1; rdy1 = 1'b1;
        neg(); chk("w1_accept", {r1_ready, v1}, {1'b1, 1'b0}); pos();
        r1_valid = 1'b0;
        neg(); chk("w1_byte", {v1, d1, r1_ready}, {1'b1, 8'h5A, 1'b0}); pos();
        neg(); chk("w1_idle", {v1, r1_ready}, {1'b0, 1'b1}); pos();
        r1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            r1_data = b2b[k];
            neg(); chk("w1_b2b_accept", {r1_ready, v1}, {1'b1, 1'b0}); pos();
            neg(); chk("w1_b2b_byte", {v1, d1, e1_ready}, {1'b1, b2b[k], 1'b0}); pos();
        end
        r1_valid = 1'b0;
        neg(); chk("w1_b2b_done", v1, 0); pos();

        // Randomized traffic, then drain
        for (int c = 0; c < 800; c++) begin
            rand_drive(1'b1);
            neg(); pos();
        end
        drained = 1'b0;
        for (int c = 0; c < 400; c++) begin
            rand_drive(1'b0);
            if (!res_valid && !echo_valid && ep_left == 0 && exp_q.size() == 0) begin
                drained = 1'b1;
                break;
            end
            neg(); pos();
        end
        chk("drain_done", drained, 1);
        chk("drain_queue", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/resp_serializer.md
# resp_serializer

Downstream stage of the command FSM/ALU. It merges two response sources into one byte stream for the UART transmitter: the FSM's echo byte stream, passed through, and ALU result words, serialized LSB byte first. Every transfer on every side uses a valid/ready handshake. A packet-level lock stops the two sources from interleaving bytes.

## Interface
- WORD_BYTES, 4, number of bytes per result word; legal range 1..8.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- echo_data_i  in  8  echo byte from the FSM.
- echo_valid_i  in  1  echo byte valid.
- echo_last_i  in  1  marks the final echo byte of a packet; sampled only on an echo handshake.
- echo_ready_o  out  1  echo byte accepted.
- res_data_i  in  8*WORD_BYTES  ALU result word.
- res_valid_i  in  1  result word valid.
- res_ready_o  out  1  result word accepted.
- data_o  out  8  byte to the UART transmitter.
- valid_o  out  1  data_o valid.
- ready_i  in  1  transmitter accepts a byte.

## Operation
- Handshakes:
  - A transfer occurs on the clock edge where valid and ready are both high.
  - A valid signal, once raised, must stay high with stable data until its transfer (upstream obligation; the block obeys the same rule on data_o/valid_o).
- State machine: IDLE, ECHO, RESULT.
- IDLE:
  - res_ready_o=1, echo_ready_o=0, valid_o=0, data_o=0.
  - If res_valid_i: the word is accepted this cycle. It is loaded into shift register sh_q, byte counter cnt_q=WORD_BYTES, next state RESULT.
  - Else if echo_valid_i: next state ECHO. No byte is transferred in IDLE, giving a one-cycle bubble.
  - If both are valid in the same cycle, result wins and echo waits.
- ECHO (locked to echo source):
  - Combinational pass-through: data_o=echo_valid_i ? echo_data_i : 0, valid_o=echo_valid_i, echo_ready_o=ready_i.
  - res_ready_o=0; any pending result waits.
  - On an echo handshake with echo_last_i=1: next state IDLE. Otherwise stay in ECHO, including while echo_valid_i is low.
- RESULT:
  - valid_o=1, data_o=sh_q[7:0] (registered path), res_ready_o=0, echo_ready_o=0.
  - On ready_i: sh_q shifts right by 8 with zero fill, and cnt_q decrements.
  - When cnt_q==1 and ready_i is high: next state IDLE, and sh_q is cleared to 0.
- Widths:
  - cnt_q is $clog2(WORD_BYTES+1) bits and never wraps; it reaches 0 only on exit.
  - sh_q is 8*WORD_BYTES bits.
- Reset:
  - Next state IDLE, sh_q=0, cnt_q=0.
  - While rst is high, all outputs are forced to 0 (valid_o, data_o, echo_ready_o, res_ready_o).
  - Reset mid-ECHO or mid-RESULT discards the remaining bytes. No partial word is resumed afterwards.

## Timing
- Result path latency:
  - Word accepted at edge N; byte 0 is presented with valid_o=1 in cycle N+1.
  - With ready_i held high, bytes go out in cycles N+1..N+WORD_BYTES.
  - IDLE in cycle N+WORD_BYTES+1, so the next word can be accepted at that edge.
  - Sustained throughput is WORD_BYTES bytes per WORD_BYTES+1 cycles.
- Echo path latency:
  - Entering ECHO costs one cycle.
  - Afterwards there is zero latency: a combinational valid/ready/data path from the echo input to the output.
  - Exit to IDLE is one cycle after the last-byte handshake.
- Backpressure:
  - ready_i low in RESULT holds data_o and valid_o stable indefinitely.
  - ready_i low in ECHO drives echo_ready_o low in the same cycle.
- Ordering:
  - No byte of one source appears between the bytes of a packet or word from the other source.
  - Sources are never reordered within themselves.

## Test plan
- **Basic result:** WORD_BYTES=4, res_data_i=0x11223344 with res_valid_i pulsed in IDLE, ready_i=1 -> data_o emits 0x44, 0x33, 0x22, 0x11 on 4 consecutive cycles starting one cycle after acceptance, then valid_o=0.
- **Backpressure:** same word with ready_i toggling 1,0,0,1,0,1,1 -> each byte is held stable while ready_i=0; the output sequence is still 44,33,22,11 with no duplicates or drops.
- **Echo packet:** 3-byte echo packet 0xAA, 0xBB, 0xCC (last on 0xCC) with ready_i=1 -> one bubble, then AA, BB, CC on consecutive cycles, echo_ready_o mirrors ready_i, IDLE after.
- **Simultaneous sources:** res_valid_i and echo_valid_i rise together in IDLE -> the 4 result bytes go out first, then ECHO is entered. A result word raised mid-echo-packet is not accepted (res_ready_o=0) until after the last echo byte.
- **Reset mid-word:** rst asserted after 2 of 4 result bytes -> outputs are 0 during rst. After release, state is IDLE, and a new word 0x01020304 emits 04, 03, 02, 01 with no leftover bytes.
- **Width edge:** WORD_BYTES=1, res_data_i=0x5A -> a single byte 0x5A, then IDLE. Back-to-back words are accepted every 2 cycles.
